// File: rtl/l2_port_arbiter.sv
// Two-master round-robin arbiter for the single-port L2 bank.
// M0 (JTAG bridge) may lock the port; a watchdog hands one slot to M1.
module l2_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOCK_MAX   = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic                    m0_req_i,
    input  logic                    m0_lock_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    lock_timeout_o
);

    localparam int unsigned CW = $clog2(LOCK_MAX) + 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(LOCK_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FORCE    = 2'd2
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   lock_cnt_q;
    logic            last_q;
    logic            rvalid_q;
    logic            rsel_q;
    logic            timeout_q;
    logic            gnt0;
    logic            gnt1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            LOCKED: begin
                gnt0 = m0_req_i;
            end
            FORCE: begin
                gnt1 = m1_req_i;
                gnt0 = m0_req_i & ~m1_req_i;
            end
            default: begin
                if (m0_req_i && m1_req_i) begin
                    gnt0 = (last_q == M1);
                    gnt1 = (last_q == M0);
                end else begin
                    gnt0 = m0_req_i;
                    gnt1 = m1_req_i;
                end
            end
        endcase
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign mem_req_o   = gnt0 | gnt1;
    assign mem_we_o    = gnt1 ? m1_we_i    : m0_we_i;
    assign mem_addr_o  = gnt1 ? m1_addr_i  : m0_addr_i;
    assign mem_be_o    = gnt1 ? m1_be_i    : m0_be_i;
    assign mem_wdata_o = gnt1 ? m1_wdata_i : m0_wdata_i;

    assign m0_rvalid_o    = rvalid_q & (rsel_q == M0);
    assign m1_rvalid_o    = rvalid_q & (rsel_q == M1);
    assign m0_rdata_o     = mem_rdata_i;
    assign m1_rdata_o     = mem_rdata_i;
    assign lock_timeout_o = timeout_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
            last_q     <= M1;
            rvalid_q   <= 1'b0;
            rsel_q     <= M0;
            timeout_q  <= 1'b0;
        end else begin
            rvalid_q  <= gnt0 | gnt1;
            rsel_q    <= gnt1;
            timeout_q <= 1'b0;
            if (gnt0 || gnt1) begin
                last_q <= gnt1;
            end
            case (state_q)
                UNLOCKED: begin
                    if (gnt0 && m0_lock_i) begin
                        state_q    <= LOCKED;
                        lock_cnt_q <= CW'(1);
                    end
                end
                LOCKED: begin
                    // Lock release wins over the watchdog in the same cycle.
                    if (!m0_lock_i) begin
                        state_q    <= UNLOCKED;
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == CNT_LIM) begin
                        state_q   <= FORCE;
                        timeout_q <= 1'b1;
                    end else if (lock_cnt_q != CNT_SAT) begin
                        lock_cnt_q <= lock_cnt_q + CW'(1);
                    end
                end
                FORCE: begin
                    state_q    <= UNLOCKED;
                    lock_cnt_q <= '0;
                end
                default: begin
                    state_q    <= UNLOCKED;
                    lock_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: vector table, directed lock
// sequences, random traffic against a rule-level model, reset mid-read.
module tb_l2_port_arbiter;

    localparam int LM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0 = 0, l0 = 0, w0 = 0, r1 = 0, w1 = 0;
    logic [15:0] a0 = '0, a1 = '0;
    logic [3:0]  b0 = '0, b1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o, mem_we_o, lock_timeout_o;
    logic [15:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    l2_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .LOCK_MAX(LM)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .m0_req_i(r0), .m0_lock_i(l0), .m0_addr_i(a0), .m0_we_i(w0),
        .m0_be_i(b0), .m0_wdata_i(d0), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(r1), .m1_addr_i(a1), .m1_we_i(w1),
        .m1_be_i(b1), .m1_wdata_i(d1), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .lock_timeout_o(lock_timeout_o)
    );

    // Behavioural SRAM: one access per cycle, read data the cycle after.
    logic [31:0] sram [0:255];
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b])
                        sram[mem_addr_o[7:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o[7:0]];
            end
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: mode 0 free, 1 locked, 2 watchdog slot.
    logic [31:0] ref_mem [0:255];
    int  m_mode, m_cnt, m_last;
    bit  m_to;
    bit  p_valid, p_read;
    int  p_owner;
    logic [31:0] p_data;
    int  last_win;
    bit  obs_g0, obs_g1, obs_to;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_last = 1; m_to = 0;
        p_valid = 0; p_read = 0; p_owner = 0; p_data = '0;
        last_win = -1;
    endtask

    task automatic tick();
        int win;
        logic [15:0] wa;
        logic [3:0]  wb;
        logic [31:0] wd;
        @(negedge clk);
        win = -1;
        if (m_mode == 0) begin
            if (r0 && r1) win = (m_last == 1) ? 0 : 1;
            else if (r0) win = 0;
            else if (r1) win = 1;
        end else if (m_mode == 1) begin
            if (r0) win = 0;
        end else begin
            if (r1) win = 1;
            else if (r0) win = 0;
        end
        obs_g0 = m0_gnt_o; obs_g1 = m1_gnt_o; obs_to = lock_timeout_o;
        check("m0_gnt", 64'(m0_gnt_o), 64'(win == 0));
        check("m1_gnt", 64'(m1_gnt_o), 64'(win == 1));
        check("mem_req", 64'(mem_req_o), 64'(win >= 0));
        if (win >= 0)
            check("mem_bus", 64'({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}),
                  (win == 0) ? 64'({w0, a0, b0, d0}) : 64'({w1, a1, b1, d1}));
        check("m0_rvalid", 64'(m0_rvalid_o), 64'(p_valid && p_owner == 0));
        check("m1_rvalid", 64'(m1_rvalid_o), 64'(p_valid && p_owner == 1));
        if (p_valid && p_read)
            check("rdata", 64'((p_owner == 0) ? m0_rdata_o : m1_rdata_o),
                  64'(p_data));
        check("lock_timeout", 64'(lock_timeout_o), 64'(m_to));
        last_win = win;
        p_valid = (win >= 0);
        p_owner = win;
        if (win >= 0) begin
            wa = (win == 0) ? a0 : a1;
            wb = (win == 0) ? b0 : b1;
            wd = (win == 0) ? d0 : d1;
            p_read = (win == 0) ? !w0 : !w1;
            p_data = ref_mem[wa[7:0]];
            if (!p_read)
                for (int b = 0; b < 4; b++)
                    if (wb[b]) ref_mem[wa[7:0]][8*b +: 8] = wd[8*b +: 8];
            m_last = win;
        end
        m_to = 0;
        if (m_mode == 0) begin
            if (win == 0 && l0) begin m_mode = 1; m_cnt = 1; end
        end else if (m_mode == 1) begin
            if (!l0) begin m_mode = 0; m_cnt = 0; end
            else if (m_cnt == LM - 1) begin m_mode = 2; m_to = 1; end
            else m_cnt++;
        end else begin
            m_mode = 0; m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit r0, l0, w0;
        logic [15:0] a0;
        logic [3:0]  b0;
        logic [31:0] d0;
        bit r1, w1;
        logic [15:0] a1;
        logic [31:0] d1;
        bit g0, g1, chk, rs;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(bit q0, bit k0, bit e0, logic [15:0] x0,
                                logic [3:0] y0, logic [31:0] z0, bit q1,
                                bit e1, logic [15:0] x1, logic [31:0] z1,
                                bit g0, bit g1, bit chk, bit rs,
                                logic [31:0] rd);
        vec_t v;
        v.r0 = q0; v.l0 = k0; v.w0 = e0; v.a0 = x0; v.b0 = y0; v.d0 = z0;
        v.r1 = q1; v.w1 = e1; v.a1 = x1; v.d1 = z1;
        v.g0 = g0; v.g1 = g1; v.chk = chk; v.rs = rs; v.rd = rd;
        return v;
    endfunction

    task automatic idle_inputs();
        r0 = 0; l0 = 0; w0 = 0; a0 = '0; b0 = '0; d0 = '0;
        r1 = 0; w1 = 0; a1 = '0; b1 = '0; d1 = '0;
    endtask

    vec_t vt[$];
    int g1_cnt, g0_cnt, to_cnt, to_idx, g1_idx;
    bit hold0, hold1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_m0_rvalid", 64'(m0_rvalid_o), 64'(0));
        check("rst_m1_rvalid", 64'(m1_rvalid_o), 64'(0));
        check("rst_timeout", 64'(lock_timeout_o), 64'(0));
        check("rst_mem_req", 64'(mem_req_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write/read, byte-enable merge, then 8 cycles of contention.
        vt.push_back(mk(1,0,1,16'h0,4'hf,32'hABBAABBA, 0,0,16'h0,32'h0, 1,0,0,0,32'h0));
        vt.push_back(mk(1,0,0,16'h0,4'hf,32'h0, 0,0,16'h0,32'h0, 1,0,1,0,32'hABBAABBA));
        vt.push_back(mk(1,0,1,16'h0,4'h2,32'h00005500, 0,0,16'h0,32'h0, 1,0,0,0,32'h0));
        vt.push_back(mk(1,0,0,16'h0,4'hf,32'h0, 0,0,16'h0,32'h0, 1,0,1,0,32'hABBA55BA));
        vt.push_back(mk(0,0,0,16'h0,4'hf,32'h0, 1,1,16'h4,32'h11112222, 0,1,0,0,32'h0));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk(1,0,0,16'h0,4'hf,32'h0, 1,0,16'h4,32'h0,
                            (i % 2) == 0, (i % 2) == 1, 1, (i % 2) == 1,
                            (i % 2) == 0 ? 32'hABBA55BA : 32'h11112222));
        foreach (vt[i]) begin
            r0 = vt[i].r0; l0 = vt[i].l0; w0 = vt[i].w0; a0 = vt[i].a0;
            b0 = vt[i].b0; d0 = vt[i].d0;
            r1 = vt[i].r1; w1 = vt[i].w1; a1 = vt[i].a1; b1 = 4'hf;
            d1 = vt[i].d1;
            tick();
            check("tbl_g0", 64'(obs_g0), 64'(vt[i].g0));
            check("tbl_g1", 64'(obs_g1), 64'(vt[i].g1));
            if (vt[i].chk) begin
                check("tbl_rvalid",
                      64'(vt[i].rs ? m1_rvalid_o : m0_rvalid_o), 64'(1));
                check("tbl_rdata",
                      64'(vt[i].rs ? m1_rdata_o : m0_rdata_o), 64'(vt[i].rd));
            end
        end

        // Lock held over 6 accesses, dropped on the 7th; M1 waits throughout.
        g1_cnt = 0; g0_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            r0 = 1; l0 = (k < 6); w0 = 1; a0 = 16'(8 + k); b0 = 4'hf;
            d0 = $urandom; r1 = 1; w1 = 0; a1 = 16'h4; b1 = 4'hf;
            tick();
            if (k < 7) begin
                g1_cnt += int'(obs_g1);
                g0_cnt += int'(obs_g0);
            end else begin
                check("lock_release_m1", 64'(obs_g1), 64'(1));
            end
        end
        check("lock_m1_starved", 64'(g1_cnt), 64'(0));
        check("lock_m0_grants", 64'(g0_cnt), 64'(7));

        // Lock held forever: watchdog gives M1 one slot, then M0 re-locks.
        to_cnt = 0; g1_cnt = 0; to_idx = -1; g1_idx = -1;
        for (int k = 0; k < 14; k++) begin
            r0 = 1; l0 = 1; w0 = 0; a0 = 16'h0; r1 = 1; w1 = 0; a1 = 16'h4;
            tick();
            if (obs_to) begin to_cnt++; to_idx = k; end
            if (obs_g1) begin g1_cnt++; g1_idx = k; end
        end
        check("wd_pulses", 64'(to_cnt), 64'(1));
        check("wd_pulse_cycle", 64'(to_idx), 64'(8));
        check("wd_m1_grants", 64'(g1_cnt), 64'(1));
        check("wd_m1_cycle", 64'(g1_idx), 64'(8));
        idle_inputs();
        repeat (2) tick();

        // Random traffic; ungranted requests are held stable.
        hold0 = 0; hold1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold0) begin
                r0 = ($urandom % 4) != 0;
                l0 = ($urandom % 5) != 0;
                w0 = $urandom % 2; a0 = 16'($urandom % 16);
                b0 = 4'($urandom); d0 = $urandom;
            end
            if (!hold1) begin
                r1 = ($urandom % 3) != 0;
                w1 = $urandom % 2; a1 = 16'($urandom % 16);
                b1 = 4'($urandom); d1 = $urandom;
            end
            tick();
            hold0 = r0 && last_win != 0;
            hold1 = r1 && last_win != 1;
        end
        idle_inputs();
        repeat (3) tick();

        // Reset between grant and response: response dropped, M0 wins next.
        r0 = 1; w0 = 1; a0 = 16'h3; b0 = 4'hf; d0 = 32'hC0DE0003;
        tick();
        r0 = 1; w0 = 0; a0 = 16'h3;
        @(negedge clk);
        check("rst_mid_gnt", 64'(m0_gnt_o), 64'(1));
        #1;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check("rst_mid_rvalid", 64'(m0_rvalid_o), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_m0_rvalid", 64'(m0_rvalid_o), 64'(0));
        check("post_rst_m1_rvalid", 64'(m1_rvalid_o), 64'(0));
        r0 = 1; w0 = 0; a0 = 16'h3; r1 = 1; w1 = 0; a1 = 16'h4;
        tick();
        check("post_rst_contention", 64'(obs_g0), 64'(1));
        idle_inputs();
        tick();
        check("post_rst_rdata", 64'(m0_rdata_o), 64'(32'hC0DE0003));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
